// File: rtl/melodia_pkg.sv
// Shared constants and FSM encoding for the melody player and its tone generator.
package melodia_pkg;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        CARGA    = 2'd1,
        TONO     = 2'd2,
        SILENCIO = 2'd3
    } estado_t;

    localparam int CLK_HZ           = 12000000;
    localparam int DUR_NOTA_DEF     = 3000000;
    localparam int DUR_SILENCIO_DEF = 600000;
    localparam int DIR_W            = 5;
    localparam int FREC_W           = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reproductor_melodia_generador_tono.sv
// Half-period counter and square-wave toggle; limpiar wins over habilitar.
module generador_tono
    import melodia_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              habilitar,
    input  logic              limpiar,
    input  logic [FREC_W-1:0] semiperiodo,
    output logic              salida
);

    logic [FREC_W-1:0] cuenta_q;
    logic              salida_q;
    logic              toca_flanco;

    // A zero half-period is a rest: the counter parks at 0 so it can never wrap.
    assign toca_flanco = (semiperiodo != '0) && (cuenta_q == semiperiodo - FREC_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuenta_q <= '0;
            salida_q <= 1'b0;
        end else if (limpiar) begin
            cuenta_q <= '0;
            salida_q <= 1'b0;
        end else if (habilitar && semiperiodo != '0) begin
            if (toca_flanco) begin
                cuenta_q <= '0;
                salida_q <= ~salida_q;
            end else begin
                cuenta_q <= cuenta_q + FREC_W'(1);
            end
        end
    end

    assign salida = salida_q;

endmodule

// File: rtl/reproductor_melodia.sv
// Walks the note ROM address by address: load, sound for DUR_NOTA cycles, then a silent gap.
module reproductor_melodia
    import melodia_pkg::*;
#(
    parameter int NUM_NOTAS    = 25,
    parameter int DUR_NOTA     = DUR_NOTA_DEF,
    parameter int DUR_SILENCIO = DUR_SILENCIO_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iniciar,
    input  logic              detener,
    input  logic              repetir,
    input  logic [FREC_W-1:0] frecuencia_de_nota,
    output logic [DIR_W-1:0]  direccion_nota,
    output logic              salida_audio,
    output logic              reproduciendo,
    output logic              fin
);

    localparam int DUR_W = $clog2(max_int(DUR_NOTA, DUR_SILENCIO) + 1);
    localparam logic [DIR_W-1:0] ULTIMA_DIR = DIR_W'(NUM_NOTAS - 1);

    estado_t           estado_q;
    logic [DIR_W-1:0]  dir_q;
    logic [FREC_W-1:0] frec_q;
    logic [DUR_W-1:0]  dur_q;
    logic              reproduciendo_q;
    logic              fin_q;
    logic              fin_tono;
    logic              fin_silencio;

    assign fin_tono     = (estado_q == TONO)     && (dur_q == DUR_W'(DUR_NOTA - 1));
    assign fin_silencio = (estado_q == SILENCIO) && (dur_q == DUR_W'(DUR_SILENCIO - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q        <= REPOSO;
            dir_q           <= '0;
            frec_q          <= '0;
            dur_q           <= '0;
            reproduciendo_q <= 1'b0;
            fin_q           <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            if (estado_q == REPOSO) begin
                if (iniciar && !detener) begin
                    estado_q        <= CARGA;
                    dir_q           <= '0;
                    reproduciendo_q <= 1'b1;
                end
            end else if (detener) begin
                estado_q        <= REPOSO;
                dir_q           <= '0;
                dur_q           <= '0;
                reproduciendo_q <= 1'b0;
            end else begin
                unique case (estado_q)
                    CARGA: begin
                        frec_q   <= frecuencia_de_nota;
                        dur_q    <= '0;
                        estado_q <= TONO;
                    end
                    TONO: begin
                        if (fin_tono) begin
                            dur_q    <= '0;
                            estado_q <= SILENCIO;
                        end else begin
                            dur_q <= dur_q + DUR_W'(1);
                        end
                    end
                    SILENCIO: begin
                        if (fin_silencio) begin
                            dur_q <= '0;
                            // repetir only matters at this end-of-melody decision.
                            if (dir_q != ULTIMA_DIR) begin
                                dir_q    <= dir_q + DIR_W'(1);
                                estado_q <= CARGA;
                            end else if (repetir) begin
                                dir_q    <= '0;
                                estado_q <= CARGA;
                            end else begin
                                dir_q           <= '0;
                                estado_q        <= REPOSO;
                                reproduciendo_q <= 1'b0;
                                fin_q           <= 1'b1;
                            end
                        end else begin
                            dur_q <= dur_q + DUR_W'(1);
                        end
                    end
                    default: estado_q <= REPOSO;
                endcase
            end
        end
    end

    generador_tono u_generador_tono (
        .clk         (clk),
        .rst_n       (rst_n),
        .habilitar   (estado_q == TONO),
        .limpiar     ((estado_q != TONO) || fin_tono || detener),
        .semiperiodo (frec_q),
        .salida      (salida_audio)
    );

    assign direccion_nota = dir_q;
    assign reproduciendo  = reproduciendo_q;
    assign fin            = fin_q;

endmodule

// File: tb/tb_reproductor_melodia.sv
// Scoreboard bench: expected per-cycle outputs are queued as stimulus is applied, then checked each cycle.
module tb_reproductor_melodia;

    localparam int DN  = 40;
    localparam int DS  = 8;
    localparam int NN  = 4;
    localparam int PER = 1 + DN + DS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iniciar;
    logic        detener;
    logic        repetir;
    logic [15:0] frec;
    logic [4:0]  dir;
    logic        sal;
    logic        repro;
    logic        fin;

    logic [15:0] rom_stub [NN] = '{16'd3, 16'd5, 16'd0, 16'd1};
    int          aristas_esp [NN] = '{14, 8, 0, 40};

    int          n_comp = 0;
    int          n_err  = 0;
    logic [7:0]  cola [$];

    always #5 clk = ~clk;

    always_comb frec = (dir < 5'(NN)) ? rom_stub[dir[1:0]] : 16'd0;

    reproductor_melodia #(
        .NUM_NOTAS    (NN),
        .DUR_NOTA     (DN),
        .DUR_SILENCIO (DS)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .iniciar            (iniciar),
        .detener            (detener),
        .repetir            (repetir),
        .frecuencia_de_nota (frec),
        .direccion_nota     (dir),
        .salida_audio       (sal),
        .reproduciendo      (repro),
        .fin                (fin)
    );

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_comp++;
        if (obs !== esp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, esp);
        end
    endtask

    // Expected {dir, salida, reproduciendo, fin} at cycle t after the first CARGA.
    function automatic logic [7:0] muestra(input int t);
        int   n = (t / PER) % NN;
        int   p = t % PER;
        int   f = int'(rom_stub[n]);
        logic s = 1'b0;
        if (p >= 1 && p <= DN && f != 0)
            s = (((p - 1) / f) % 2) != 0;
        return {5'(n), s, 1'b1, 1'b0};
    endfunction

    function automatic logic [7:0] reposo(input logic f);
        return {5'd0, 1'b0, 1'b0, f};
    endfunction

    task automatic paso(input string tag, input int t);
        logic [7:0] e;
        @(negedge clk);
        comprobar($sformatf("%s_cola_t%0d", tag, t), 32'(cola.size() > 0), 32'd1);
        if (cola.size() > 0) begin
            e = cola.pop_front();
            comprobar($sformatf("%s_t%0d", tag, t), 32'({dir, sal, repro, fin}), 32'(e));
        end
    endtask

    initial begin
        int aristas;
        logic prev;

        rst_n = 1'b0; iniciar = 1'b0; detener = 1'b0; repetir = 1'b0;
        #3;
        comprobar("reset_dir",   32'(dir),   32'd0);
        comprobar("reset_sal",   32'(sal),   32'd0);
        comprobar("reset_repro", 32'(repro), 32'd0);
        comprobar("reset_fin",   32'(fin),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic playback through all four notes, ending with a fin pulse.
        iniciar = 1'b1;
        for (int t = 0; t < NN * PER; t++) cola.push_back(muestra(t));
        cola.push_back(reposo(1'b1));
        cola.push_back(reposo(1'b0));
        aristas = 0;
        prev = 1'b0;
        for (int t = 0; t < NN * PER + 2; t++) begin
            paso("basico", t);
            if (t == 0) iniciar = 1'b0;
            if (t < NN * PER) begin
                if (sal != prev) aristas++;
                prev = sal;
                if (t % PER == PER - 1) begin
                    comprobar($sformatf("aristas_nota%0d", t / PER), 32'(aristas), 32'(aristas_esp[t / PER]));
                    $display("nota %0d: frec=%0d aristas=%0d", t / PER, rom_stub[t / PER], aristas);
                    aristas = 0;
                end
            end
        end

        // Loop once, then drop repetir during the second pass.
        repetir = 1'b1;
        iniciar = 1'b1;
        for (int t = 0; t < 2 * NN * PER; t++) cola.push_back(muestra(t));
        cola.push_back(reposo(1'b1));
        cola.push_back(reposo(1'b0));
        for (int t = 0; t < 2 * NN * PER + 2; t++) begin
            paso("bucle", t);
            if (t == 0) iniciar = 1'b0;
            if (t == NN * PER + PER + 10) repetir = 1'b0;
        end
        $display("bucle: two passes played, fin after second pass");

        // Stop at TONO k=17 of address 1, then restart from address 0.
        iniciar = 1'b1;
        for (int t = 0; t <= PER + 1 + 17; t++) cola.push_back(muestra(t));
        for (int t = 0; t <= PER + 1 + 17; t++) begin
            paso("parada", t);
            if (t == 0) iniciar = 1'b0;
        end
        detener = 1'b1;
        for (int i = 0; i < 6; i++) cola.push_back(reposo(1'b0));
        paso("parada_post", 0);
        detener = 1'b0;
        for (int i = 1; i < 6; i++) paso("parada_post", i);
        iniciar = 1'b1;
        for (int t = 0; t < PER; t++) cola.push_back(muestra(t));
        for (int t = 0; t < PER; t++) begin
            paso("reinicio", t);
            if (t == 0) iniciar = 1'b0;
        end
        detener = 1'b1;
        cola.push_back(reposo(1'b0));
        paso("reinicio_parada", 0);
        detener = 1'b0;
        $display("parada: stopped mid-tone, restarted at address 0");

        // Ignored iniciar during TONO, then asynchronous reset mid-SILENCIO.
        iniciar = 1'b1;
        for (int t = 0; t <= 2 * PER + 1 + DN + 3; t++) cola.push_back(muestra(t));
        for (int t = 0; t <= 2 * PER + 1 + DN + 3; t++) begin
            paso("ignorado", t);
            if (t == 0)  iniciar = 1'b0;
            if (t == 10) iniciar = 1'b1;
            if (t == 11) iniciar = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        comprobar("async_dir",   32'(dir),   32'd0);
        comprobar("async_sal",   32'(sal),   32'd0);
        comprobar("async_repro", 32'(repro), 32'd0);
        comprobar("async_fin",   32'(fin),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: asynchronous clear mid-gap");

        // iniciar and detener together in REPOSO: stay idle.
        iniciar = 1'b1;
        detener = 1'b1;
        for (int i = 0; i < 3; i++) cola.push_back(reposo(1'b0));
        paso("ambos", 0);
        iniciar = 1'b0;
        detener = 1'b0;
        paso("ambos", 1);
        paso("ambos", 2);
        $display("ambos: iniciar+detener in REPOSO stays idle");

        comprobar("cola_final", 32'(cola.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_err);
        $finish;
    end

endmodule
